// File: rtl/pc_next_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_next_unit
//  Brief    : Program-counter stage. Holds the registered fetch PC and
//             resolves jr / jump / taken-branch redirects with fixed
//             priority. It flags misaligned redirect targets, steering them
//             to the exception vector, and drives fetch valid and flush.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_next_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset_sh,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        pc_valid,
  output logic        flush,
  output logic        misaligned
);

  // Front-end sequencing states
  localparam logic [1:0] BOOT     = 2'd0;
  localparam logic [1:0] RUN      = 2'd1;
  localparam logic [1:0] REDIRECT = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic        r_misaligned;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;
  logic        w_redirect;
  logic        w_target_misaligned;

  // Sequential address and redirect target, selected by fixed priority
  // jr > jump > branch. Lower-priority requests are simply dropped.
  always_comb begin
    w_pc_plus4 = r_pc + 32'd4;
    w_redirect = jr | jump | branch_taken;
    w_target   = w_pc_plus4;
    if (jr) begin
      w_target = jr_target;
    end else if (jump) begin
      w_target = {w_pc_plus4[31:28], jump_index, 2'b00};
    end else if (branch_taken) begin
      w_target = w_pc_plus4 + branch_offset_sh;
    end
    // A jump target always has its low bits clear, so this check only fires
    // for jr and branch targets.
    w_target_misaligned = (w_target[1:0] != 2'b00);
  end

  // PC register, sticky misalignment flag, and state machine
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= BOOT;
      r_pc         <= RESET_VECTOR;
      r_misaligned <= 1'b0;
    end else begin
      case (r_state)
        BOOT: begin
          r_state <= RUN;
        end
        RUN: begin
          if (!stall) begin
            if (w_redirect) begin
              r_state <= REDIRECT;
              if (w_target_misaligned) begin
                r_pc         <= EXC_VECTOR;
                r_misaligned <= 1'b1;
              end else begin
                r_pc <= w_target;
              end
            end else begin
              r_pc <= w_pc_plus4;
            end
          end
        end
        REDIRECT: begin
          // The flush bubble is exactly one cycle, even when stall is high.
          r_state <= RUN;
        end
        default: begin
          r_state <= BOOT;
        end
      endcase
    end
  end

  // Moore outputs decoded from state
  always_comb begin
    pc_valid = (r_state == RUN);
    flush    = (r_state == REDIRECT);
  end

  assign pc         = r_pc;
  assign pc_plus4   = w_pc_plus4;
  assign misaligned = r_misaligned;

endmodule
`default_nettype wire

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Program-counter stage directly downstream of the word-offset shift stage.
- Holds the registered PC and consumes the already-shifted branch offset (offset<<2) to form the branch target.
- Also resolves jump and jump-register redirects, and flags misaligned targets.
- Drives instruction fetch with pc/pc_valid and tells the pipeline front end to discard wrong-path work via flush.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
EXC_VECTOR, 32'h0000_0080, PC loaded when a misaligned redirect target is detected.

Ports:
clk  input  1  rising-edge clock.
reset_n  input  1  asynchronous, active-low reset.
stall  input  1  hold PC; all redirect inputs ignored while high.
branch_taken  input  1  conditional branch resolved taken this cycle.
branch_offset_sh  input  32  sign-extended offset already shifted left 2 (from shift stage).
jump  input  1  J/JAL this cycle.
jump_index  input  26  instr_index field of J-type instruction.
jr  input  1  JR/JALR this cycle.
jr_target  input  32  register target for jr.
pc  output  32  current fetch address (registered).
pc_plus4  output  32  pc + 4, combinational from pc, wraps mod 2^32.
pc_valid  output  1  pc is a fetchable, non-flushed address.
flush  output  1  discard the instruction fetched in the previous cycle.
misaligned  output  1  sticky: a redirect target had bits[1:0] != 0.

Behaviour:
- Reset (reset_n low, asynchronous):
  - pc=RESET_VECTOR, state=BOOT, pc_valid=0, flush=0, misaligned=0.
  - Reset mid-operation aborts any redirect immediately.
- State machine: BOOT, RUN, REDIRECT. Outputs decoded from state (Moore):
  - BOOT: pc_valid=0, flush=0.
  - RUN: pc_valid=1, flush=0.
  - REDIRECT: pc_valid=0, flush=1.
- BOOT -> RUN on the first rising edge after reset release. pc is unchanged and stall is ignored in BOOT.
- RUN, stall=1: pc and state held; branch_taken/jump/jr ignored (not queued).
- RUN, stall=0: next pc is selected by fixed priority jr > jump > branch_taken > sequential.
  - jr: target = jr_target.
  - jump: target = {pc_plus4[31:28], jump_index, 2'b00}.
  - branch_taken: target = pc_plus4 + branch_offset_sh, 32-bit add, carry discarded (wraps).
  - sequential: pc <= pc_plus4, state stays RUN.
  - Any redirect: pc <= target, state -> REDIRECT.
- Misalignment:
  - If the selected target has bits[1:0] != 0: pc <= EXC_VECTOR, misaligned <= 1 (sticky until reset), state -> REDIRECT.
  - The jump target is always aligned by construction; jr and branch targets are checked.
- REDIRECT lasts exactly one cycle, independent of stall: next edge -> RUN with pc unchanged. Redirect inputs are ignored in REDIRECT.
- Latency:
  - A redirect sampled at edge N makes pc=target visible after N.
  - pc_valid rises after edge N+1.
- Simultaneous requests resolve by priority only; the lower-priority requests are dropped.
- Wrap-around: pc=32'hFFFF_FFFC sequential -> 32'h0000_0000, no flag.

Test Plan:
- Reset/boot: reset_n low then high, stall=0 -> pc=0x0, pc_valid=0 for one cycle; then pc=0x0, pc_valid=1; next edge pc=0x4. Asserting reset_n low mid-run forces pc=0x0 immediately, without a clock edge.
- Branch:
  - pc=0x100, branch_taken=1, branch_offset_sh=0x118 (70<<2) -> pc=0x21C, flush=1, pc_valid=0 one cycle; then pc_valid=1, pc=0x21C; next pc=0x220.
  - Negative: pc=0x100, branch_offset_sh=0xFFFFFFF0 -> pc=0xF4.
- Priority: pc=0x40, jr=1 jr_target=0x800, jump=1 jump_index=0x10, branch_taken=1 -> pc=0x800. Repeat with jr=0 -> pc=0x40.
- Stall:
  - stall=1 for 3 cycles with branch_taken=1 -> pc held, no flush. After stall drops with branch_taken=0 -> pc advances by 4 only.
  - stall=1 during REDIRECT -> REDIRECT still exits after one cycle.
- Misaligned: jr=1, jr_target=0x802 -> pc=0x80, misaligned=1, flush pulse. misaligned stays 1 through later normal fetches until reset_n low.
- Wrap: pc=0xFFFFFFFC sequential -> pc=0x0. With pc=0xFFFFFFF8, branch_offset_sh=0x8 -> target 0x4 (wrapped).
